updown_counter_ctrl: RTL and testbench
======================================

Name: updown_counter_ctrl

Overview:
Sequencing controller for the 4-bit up/down counter and its 7-segment display path. It turns raw pushbutton inputs (run/pause, step, direction, clear) into clean single-cycle control pulses, then drives the counter's count-enable, direction and clear inputs. A prescaler spaces count ticks during free-running mode. It sits between the board buttons and the counter. The counter's value is fed back for terminal detection.

Parameters:
- DIV, 10, clk cycles per count tick in RUN state; legal range DIV >= 1.
- CNT_W, 4, width of the counter value fed back on count_in.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_run  in  1  async pushbutton; rising edge toggles run/pause.
- btn_step  in  1  async pushbutton; rising edge requests a single count.
- btn_dir  in  1  async pushbutton; rising edge toggles direction.
- btn_clr  in  1  async pushbutton; rising edge clears counter and stops.
- count_in  in  CNT_W  current counter value. Used only with AUTO_REVERSE_EN.
- cnt_en  out  1  one-cycle count-enable pulse to the counter.
- ud  out  1  direction to the counter: 1 = up, 0 = down.
- cnt_clr  out  1  one-cycle clear pulse to the counter.
- state_o  out  2  current FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Reset (rst=0, async): state IDLE, prescaler 0, cnt_en=0, cnt_clr=0, ud=1, sync/edge flops 0.
- Reset mid-operation: all of the above apply immediately; any pending tick is lost.
- Each button path:
  - 2-flop synchronizer, then a delay flop.
  - Edge pulse xx_pe = s2 & ~s3.
  - Input high before edge k gives xx_pe high during cycle k+1.
  - Registered outputs react at edge k+2.
  - Holding a button generates exactly one pulse.
- All outputs are registered; cnt_en and cnt_clr are never high for more than one cycle.
- Clear:
  - clr_pe in any state: cnt_clr=1 for one cycle, prescaler <= 0, state <= IDLE, cnt_en=0 that cycle, ud unchanged.
  - clr_pe has priority over all other events.
- IDLE:
  - run_pe -> RUN, prescaler <= 0.
  - step_pe -> cnt_en pulse, stay in IDLE.
  - run_pe and step_pe together: run wins, step dropped.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - cnt_en=1 on the cycle after prescaler==DIV-1, giving one pulse every DIV cycles.
  - First pulse occurs DIV cycles after entering RUN.
  - DIV=1: cnt_en is high every cycle.
  - run_pe -> PAUSE; prescaler is held and no tick is issued that cycle.
  - step_pe is ignored.
- PAUSE:
  - run_pe -> RUN, resuming from the held prescaler value.
  - step_pe -> one cnt_en pulse; prescaler unchanged.
  - run and step together: run wins.
- Direction:
  - dir_pe toggles ud in any state, including during clear.
  - If a toggle and a tick coincide, the new ud and cnt_en appear on the same edge, so the counter steps in the new direction.
- Encoding state 11 is unreachable. If ever entered, the FSM goes to IDLE next cycle.

Optional Feature:
- Macro: UPDOWN_CTRL_AUTO_REVERSE_EN.
- Defined:
  - In RUN only, when issuing a tick with ud=1 and count_in == 2^CNT_W-1, ud <= 0 on the same edge. The counter then goes 15 -> 14.
  - Symmetrically, with ud=0 and count_in == 0, ud <= 1.
  - dir_pe in the same cycle takes priority; auto-reverse is suppressed that cycle.
  - Step pulses never auto-reverse.
- Undefined: count_in is unused and the counter wraps naturally.

Decomposition:
- Package updown_ctrl_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
  - UD_UP=1'b1, UD_DOWN=1'b0.
  - Prescaler width function clog2(DIV), minimum 1.
- Sub-module btn_edge: synchronizer plus rising-edge detector with clk/rst. Instantiated four times.

Test Plan:
- Reset with rst=0 for 3 cycles -> state_o=00, ud=1, cnt_en=0, cnt_clr=0; all outputs stay there while rst=0 despite button activity.
- DIV=4, pulse btn_run -> state_o=01 two edges later; cnt_en pulses every 4th cycle; 10 pulses counted in 40 cycles; btn_step pulse causes no extra pulse.
- DIV=4, in RUN at prescaler=2 press btn_run -> PAUSE, no cnt_en; press btn_step twice -> exactly 2 cnt_en pulses; press btn_run -> next cnt_en 2 cycles after resume.
- btn_dir held 20 cycles -> ud toggles exactly once (1 -> 0); btn_dir aligned with a tick -> cnt_en and ud=0 asserted on the same edge.
- In RUN, btn_clr and btn_dir pressed together -> cnt_clr=1 for one cycle, state_o=00, ud toggled, no cnt_en.
- With UPDOWN_CTRL_AUTO_REVERSE_EN, DIV=1, count_in fed from a model counter starting at 13 -> sequence 14, 15, 14, 13; ud drops with the tick at 15. Without the macro -> 14, 15, 0, 1.

Source files
------------

// File: rtl/updown_ctrl_pkg.sv
// Shared encodings and sizing helper for the up/down counter controller.
// Pure declarations: no latency, no flow control.
package updown_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic UD_UP   = 1'b1;
  localparam logic UD_DOWN = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE
  } state_t;

  // Prescaler must hold 0..div-1; never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Pushbutton synchronizer and rising-edge detector; pe is high one cycle, two edges after the input rises.
// No backpressure: holding the button yields exactly one pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pe
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pe = s2 & ~s3;

endmodule

// File: rtl/updown_counter_ctrl.sv
// Button-driven run/pause/step/clear sequencer for the 4-bit up/down counter; outputs react two edges after a button edge.
// No backpressure. UPDOWN_CTRL_AUTO_REVERSE_EN flips direction at the count terminals while running.
module updown_counter_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_dir,
  input  logic             btn_clr,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_en,
  output logic             ud,
  output logic             cnt_clr,
  output logic [1:0]       state_o
);

  localparam int            PW        = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic run_pe, step_pe, dir_pe, clr_pe;
  logic rev;
  state_t        state_q;
  logic [PW-1:0] presc;

  btn_edge u_run  (.clk(clk), .rst(rst), .btn(btn_run),  .pe(run_pe));
  btn_edge u_step (.clk(clk), .rst(rst), .btn(btn_step), .pe(step_pe));
  btn_edge u_dir  (.clk(clk), .rst(rst), .btn(btn_dir),  .pe(dir_pe));
  btn_edge u_clr  (.clk(clk), .rst(rst), .btn(btn_clr),  .pe(clr_pe));

`ifdef UPDOWN_CTRL_AUTO_REVERSE_EN
  // Terminal test uses the value the counter will hold once any pulse already
  // in flight lands, so back-to-back ticks (DIV=1) reverse at the right count.
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = count_in;
    if (cnt_clr)
      cnt_next = '0;
    else if (cnt_en)
      cnt_next = (ud == UD_UP) ? count_in + 1'b1 : count_in - 1'b1;
  end

  assign rev = (ud == UD_UP) ? (&cnt_next) : ~(|cnt_next);
`else
  logic unused_count;
  assign unused_count = ^count_in;
  assign rev          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      ud      <= UD_UP;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      if (dir_pe)
        ud <= ~ud;

      if (clr_pe) begin
        cnt_clr <= 1'b1;
        presc   <= '0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_pe) begin
              state_q <= S_RUN;
              presc   <= '0;
            end else if (step_pe) begin
              cnt_en <= 1'b1;
            end
          end
          S_RUN: begin
            if (run_pe) begin
              state_q <= S_PAUSE;
            end else if (presc == PRESC_MAX) begin
              presc  <= '0;
              cnt_en <= 1'b1;
              if (!dir_pe && rev)
                ud <= ~ud;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          S_PAUSE: begin
            if (run_pe)
              state_q <= S_RUN;
            else if (step_pe)
              cnt_en <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            presc   <= '0;
          end
        endcase
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Scoreboard bench: DIV=4 instance for sequencing, DIV=1 instance driving a model counter.
// Expected tick cycles and counter values are queued at stimulus time.
module tb_updown_counter_ctrl;
  import updown_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btns  = '0;   // {clr, dir, step, run}
  logic [3:0] btns1 = '0;
  logic [3:0] cnt_fix = 4'd5;
  logic       cnt_en, ud, cnt_clr;
  logic [1:0] state_o;
  logic       cnt_en1, ud1, cnt_clr1;
  logic [1:0] state1;
  logic [3:0] model_cnt = 4'd13;
  logic [3:0] prev_cnt  = 4'd13;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_ticks = 0;
  int tick_q[$];
  int cnt_q[$];

  always #5 clk = ~clk;

  updown_counter_ctrl #(.DIV(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btns[0]), .btn_step(btns[1]), .btn_dir(btns[2]), .btn_clr(btns[3]),
    .count_in(cnt_fix),
    .cnt_en(cnt_en), .ud(ud), .cnt_clr(cnt_clr), .state_o(state_o)
  );

  updown_counter_ctrl #(.DIV(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .btn_run(btns1[0]), .btn_step(btns1[1]), .btn_dir(btns1[2]), .btn_clr(btns1[3]),
    .count_in(model_cnt),
    .cnt_en(cnt_en1), .ud(ud1), .cnt_clr(cnt_clr1), .state_o(state1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    btns = m;
    @(negedge clk);
    btns = '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model fed back to the DIV=1 instance.
  always @(posedge clk) begin
    if (cnt_clr1)
      model_cnt <= '0;
    else if (cnt_en1)
      model_cnt <= (ud1 == UD_UP) ? model_cnt + 4'd1 : model_cnt - 4'd1;
  end

  always @(negedge clk) begin
    if (tick_q.size() > 0 && tick_q[0] == cyc) begin
      check("tick", cnt_en, 1);
      void'(tick_q.pop_front());
    end else if (cnt_en === 1'b1) begin
      check("tick_extra", cnt_en, 0);
    end
    if (cnt_en === 1'b1) n_ticks++;

    if (model_cnt !== prev_cnt && cnt_q.size() > 0)
      check("count_seq", model_cnt, cnt_q.pop_front());
    prev_cnt = model_cnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e, p, s, s2, n0, h, d0, r, a;

    // Reset held, with button activity underneath it.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, ST_IDLE);
    check("rst_ud", ud, UD_UP);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    btns = 4'b1111;
    repeat (4) @(negedge clk);
    check("rst_hold_state", state_o, ST_IDLE);
    check("rst_hold_ud", ud, UD_UP);
    check("rst_hold_cnt_en", cnt_en, 0);
    check("rst_hold_cnt_clr", cnt_clr, 0);
    check("rst_hold_state1", state1, ST_IDLE);
    btns = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", state_o, ST_IDLE);

    // Free run at DIV=4.
    c0 = cyc;
    e  = c0 + 3;
    for (int i = 1; i <= 11; i++) tick_q.push_back(e + 4 * i);
    press(4'b0001);
    wait_cyc(e - 1);
    check("run_not_yet", state_o, ST_IDLE);
    wait_cyc(e);
    check("run_entered", state_o, ST_RUN);
    n0 = n_ticks;
    wait_cyc(e + 21);
    press(4'b0010);                       // step is ignored while running
    wait_cyc(e + 41);
    check("ticks_in_40", n_ticks - n0, 10);

    // Pause with prescaler at 2.
    wait_cyc(e + 44);
    press(4'b0001);
    p = e + 47;
    wait_cyc(p);
    check("pause_state", state_o, ST_PAUSE);
    check("pause_no_tick", cnt_en, 0);
    wait_cyc(p + 5);
    check("pause_hold", state_o, ST_PAUSE);

    n0 = n_ticks;
    s = cyc;
    tick_q.push_back(s + 3);
    press(4'b0010);
    wait_cyc(s + 4);
    s2 = cyc;
    tick_q.push_back(s2 + 3);
    press(4'b0010);
    wait_cyc(s2 + 6);
    check("pause_steps", n_ticks - n0, 2);
    check("pause_still", state_o, ST_PAUSE);

    // Direction held for 20 cycles toggles once.
    h = cyc;
    btns[2] = 1'b1;
    wait_cyc(h + 2);
    check("dir_before", ud, UD_UP);
    wait_cyc(h + 3);
    check("dir_toggled", ud, UD_DOWN);
    wait_cyc(h + 20);
    btns = '0;
    wait_cyc(h + 26);
    check("dir_once", ud, UD_DOWN);
    d0 = cyc;
    press(4'b0100);
    wait_cyc(d0 + 3);
    check("dir_back_up", ud, UD_UP);

    // Resume from held prescaler, then a direction edge aligned with a tick.
    r = cyc;
    tick_q.push_back(r + 5);
    tick_q.push_back(r + 9);
    press(4'b0001);
    wait_cyc(r + 3);
    check("resume_state", state_o, ST_RUN);
    wait_cyc(r + 6);
    press(4'b0100);
    wait_cyc(r + 8);
    press(4'b1100);                       // clear and direction together
    check("aligned_cnt_en", cnt_en, 1);
    check("aligned_ud", ud, UD_DOWN);
    wait_cyc(r + 11);
    check("clr_pulse", cnt_clr, 1);
    check("clr_state", state_o, ST_IDLE);
    check("clr_ud", ud, UD_UP);
    check("clr_no_tick", cnt_en, 0);
    wait_cyc(r + 12);
    check("clr_one_cycle", cnt_clr, 0);
    wait_cyc(r + 16);
    check("clr_stays_idle", state_o, ST_IDLE);

    // DIV=1 instance against the model counter starting at 13.
    cnt_q.push_back(14);
    cnt_q.push_back(15);
`ifdef UPDOWN_CTRL_AUTO_REVERSE_EN
    cnt_q.push_back(14);
    cnt_q.push_back(13);
`else
    cnt_q.push_back(0);
    cnt_q.push_back(1);
`endif
    a = cyc;
    btns1 = 4'b0001;
    @(negedge clk);
    btns1 = '0;
    wait_cyc(a + 5);
    check("div1_ud_early", ud1, UD_UP);
    wait_cyc(a + 6);
`ifdef UPDOWN_CTRL_AUTO_REVERSE_EN
    check("div1_ud_at_15", ud1, UD_DOWN);
`else
    check("div1_ud_at_15", ud1, UD_UP);
`endif
    check("div1_tick", cnt_en1, 1);
    wait_cyc(a + 10);
    check("count_seq_done", cnt_q.size(), 0);
    check("ticks_done", tick_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
